// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl
//   Front-end fetch sequencer. Issues fixed-length INCR bursts of 64-bit beats
//   on the ICache AXI read port, starting from a sequential fetch PC, and queues
//   the returned beats in a small FIFO feeding decode (2 instructions per beat).
//   A redirect flushes the FIFO and restarts fetch at redirect_pc. If the
//   redirect lands while a burst is in flight, the rest of that burst is drained
//   and discarded, so the AXI protocol is never violated.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   redirect_valid/redirect_pc flush and restart fetch at a new 4-byte aligned PC
//   arvalid/araddr/arburst/arsize/arlen/arready   AXI AR channel (master side)
//   rvalid/rdata/rlast/rready                     AXI R channel (master side)
//   fetch_valid/fetch_pc/fetch_data/fetch_ready   FIFO head towards decode;
//                              fetch_pc[2]=1 marks the low instruction invalid
module icache_fetch_ctrl #(
  parameter int          BURST_LEN  = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [1:0]  arburst,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [63:0] rdata,
  input  logic        rlast,
  output logic        rready,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [63:0] fetch_data,
  input  logic        fetch_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BL_C    = CW'(BURST_LEN);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
  localparam logic [31:0]   BURST_BYTES = 32'(8 * BURST_LEN);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] data;
  } fetch_entry_t;

  state_t       state, state_nxt;
  logic [31:0]  fpc, fpc_nxt;
  logic         kill, kill_nxt;
  logic [31:0]  bpc;
  logic [31:0]  araddr_q;

  fetch_entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;
  logic                push, pop, can_issue;

  // Issue only when a whole burst fits; this reserves the slots so the
  // FIFO can never overflow while beats stream in.
  assign can_issue = (DEPTH_C - count) >= BL_C;

  // Beats are only kept in DATA; a redirect that same cycle wins over the push.
  assign push = (state == DATA) && rvalid && !redirect_valid;
  assign pop  = fetch_valid && fetch_ready;

  assign arvalid = (state == ADDR);
  assign araddr  = araddr_q;
  assign arburst = 2'b01;
  assign arsize  = 3'b011;
  assign arlen   = 8'(BURST_LEN - 1);
  assign rready  = (state == DATA) || (state == DRAIN);

  always_comb begin
    state_nxt = state;
    fpc_nxt   = fpc;
    kill_nxt  = kill;
    case (state)
      IDLE: if (can_issue) state_nxt = ADDR;
      ADDR: begin
        if (arready) begin
          // An accepted AR must be followed by its data; a pending or
          // same-cycle redirect turns that data into a drain.
          state_nxt = (kill || redirect_valid) ? DRAIN : DATA;
          kill_nxt  = 1'b0;
        end else if (redirect_valid) begin
          kill_nxt  = 1'b1;
        end
      end
      DATA: begin
        if (rvalid && rlast) begin
          state_nxt = IDLE;
          fpc_nxt   = {fpc[31:3], 3'b000} + BURST_BYTES;
        end else if (redirect_valid) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: if (rvalid && rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) fpc_nxt = redirect_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fpc      <= RESET_PC;
      kill     <= 1'b0;
      bpc      <= RESET_PC;
      araddr_q <= 32'h0;
    end else begin
      state <= state_nxt;
      fpc   <= fpc_nxt;
      kill  <= kill_nxt;
      // Address is captured on entry to ADDR and then held until handshake.
      if (state == IDLE && state_nxt == ADDR)
        araddr_q <= {fpc_nxt[31:3], 3'b000};
      if (state == ADDR && arready)
        bpc <= fpc;
      else if (push)
        // Only the first beat of a burst can carry pc[2]; later beats are aligned.
        bpc <= {bpc[31:3] + 29'd1, 3'b000};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: bpc, data: rdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fetch_valid = (count != '0);
  assign fetch_pc    = mem[rd_ptr].pc;
  assign fetch_data  = mem[rd_ptr].data;

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
module tb_icache_fetch_ctrl;
  localparam int BL = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [1:0]  arburst;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic        rvalid = 1'b0, rlast = 1'b0, rready;
  logic [63:0] rdata = '0;
  logic        fetch_valid, fetch_ready = 1'b0;
  logic [31:0] fetch_pc;
  logic [63:0] fetch_data;

  always #5 clk = ~clk;

  icache_fetch_ctrl #(.BURST_LEN(BL), .FIFO_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .arvalid(arvalid), .araddr(araddr), .arburst(arburst), .arsize(arsize),
    .arlen(arlen), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_data(fetch_data),
    .fetch_ready(fetch_ready)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] data;
  } ent_t;

  ent_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode side: every accepted head entry is popped from the scoreboard.
  always @(negedge clk) begin
    if (rst_n && fetch_valid === 1'b1 && fetch_ready) begin
      if (exp_q.size() == 0) chk("fetch_unexpected_valid", fetch_valid, 1'b0);
      else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("fetch_entry", {fetch_pc, fetch_data}, {e.pc, e.data});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    exp_q.delete();
    #1;
    chk("reset_outputs", {arvalid, rready, fetch_valid}, 3'b000);
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ar();
    int n = 0;
    while (arvalid !== 1'b1 && n < 20) begin tick(); n++; end
  endtask

  task automatic do_ar(input logic [31:0] addr, input string tag);
    wait_ar();
    chk({tag, "_arvalid"}, arvalid, 1'b1);
    chk({tag, "_araddr"}, araddr, addr);
    chk({tag, "_arattr"}, {arlen, arburst, arsize}, {8'd3, 2'b01, 3'b011});
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  // Slave returns one burst; beat data is {~addr, addr}. A redirect can be
  // raised on beat redir_at, after which nothing more is expected in the FIFO.
  task automatic send_beats(input logic [31:0] first_pc, input bit keep,
                            input int redir_at, input logic [31:0] rpc);
    logic [31:0] a;
    bit k;
    ent_t e;
    k = keep;
    for (int i = 0; i < BL; i++) begin
      a = {first_pc[31:3], 3'b000} + 32'(8 * i);
      rvalid = 1'b1; rdata = {~a, a}; rlast = (i == BL - 1);
      if (i == redir_at) begin
        redirect_valid = 1'b1; redirect_pc = rpc; k = 1'b0;
        exp_q.delete();
      end
      chk("beat_rready", rready, 1'b1);
      if (k) begin
        e.pc = (i == 0) ? first_pc : a;
        e.data = {~a, a};
        exp_q.push_back(e);
      end
      tick();
      redirect_valid = 1'b0;
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    fetch_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
    chk({tag, "_sb_empty"}, 96'(exp_q.size()), 96'd0);
    chk({tag, "_fifo_empty"}, fetch_valid, 1'b0);
  endtask

  // Redirect while AR is pending; with_ready=1 puts the handshake in the same cycle.
  task automatic redir_in_addr(input logic [31:0] old, input logic [31:0] rpc,
                               input bit with_ready, input string tag);
    wait_ar();
    chk({tag, "_pre_araddr"}, araddr, old);
    redirect_valid = 1'b1; redirect_pc = rpc; arready = with_ready;
    tick();
    redirect_valid = 1'b0; arready = 1'b0;
    if (!with_ready) begin
      chk({tag, "_ar_held"}, {arvalid, araddr}, {1'b1, old});
      arready = 1'b1;
      tick();
      arready = 1'b0;
    end
    send_beats(old, 1'b0, -1, 32'h0);
    chk({tag, "_nothing_enq"}, fetch_valid, 1'b0);
  endtask

  initial begin
    bit seen;

    // Basic streaming: two back-to-back bursts, decode always ready.
    fetch_ready = 1'b1;
    do_reset();
    tick();
    chk("first_arvalid", arvalid, 1'b1);
    do_ar(32'h0, "s1a");
    send_beats(32'h0, 1'b1, -1, 32'h0);
    do_ar(32'h20, "s1b");
    send_beats(32'h20, 1'b1, -1, 32'h0);
    wait_empty("s1");

    // Back-pressure: FIFO fills after two bursts, frees 4 slots, issues again.
    fetch_ready = 1'b0;
    do_reset();
    do_ar(32'h0, "s2a");
    send_beats(32'h0, 1'b1, -1, 32'h0);
    do_ar(32'h20, "s2b");
    send_beats(32'h20, 1'b1, -1, 32'h0);
    seen = 1'b0;
    repeat (6) begin seen |= arvalid; tick(); end
    chk("s2_no_third_ar", seen, 1'b0);
    chk("s2_full_valid", fetch_valid, 1'b1);
    fetch_ready = 1'b1;
    repeat (4) tick();
    fetch_ready = 1'b0;
    do_ar(32'h40, "s2c");
    send_beats(32'h40, 1'b1, -1, 32'h0);
    wait_empty("s2");

    // AR stall for 5 cycles with stray R beats that must be ignored.
    fetch_ready = 1'b1;
    do_reset();
    wait_ar();
    repeat (5) begin
      rvalid = 1'b1; rlast = 1'b1; rdata = 64'hDEAD_BEEF_0BAD_F00D;
      chk("s3_stall", {arvalid, araddr, rready}, {1'b1, 32'h0, 1'b0});
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    chk("s3_no_early_beat", fetch_valid, 1'b0);
    do_ar(32'h0, "s3");
    send_beats(32'h0, 1'b1, -1, 32'h0);
    wait_empty("s3");

    // Redirect on beat 2 of a burst.
    fetch_ready = 1'b0;
    do_reset();
    do_ar(32'h0, "s4a");
    send_beats(32'h0, 1'b1, 1, 32'h104);
    chk("s4_flushed", fetch_valid, 1'b0);
    do_ar(32'h100, "s4b");
    send_beats(32'h104, 1'b1, -1, 32'h0);
    wait_empty("s4");

    // Redirect in ADDR without arready: the burst is drained, then 0x200.
    redir_in_addr(32'h120, 32'h200, 1'b0, "s5");
    do_ar(32'h200, "s5b");
    send_beats(32'h200, 1'b1, -1, 32'h0);
    wait_empty("s5");

    // Redirect coinciding with arready, then 32-bit PC wrap.
    redir_in_addr(32'h220, 32'hFFFF_FFE0, 1'b1, "s6");
    do_ar(32'hFFFF_FFE0, "s6b");
    send_beats(32'hFFFF_FFE0, 1'b1, -1, 32'h0);
    do_ar(32'h0, "s6_wrap");
    send_beats(32'h0, 1'b1, -1, 32'h0);
    wait_empty("s6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
